dff_pipe: RTL
=============

# dff_pipe

Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage elastic register pipeline with a valid/ready handshake on both sides and an occupancy counter. It sits between a producer and a consumer that may stall. It gives a fixed minimum latency of DEPTH cycles, compresses bubbles and runs at full throughput under backpressure. Verification reuses the dff interface style: one clock, clocking-block driven inputs and sampled outputs.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 3, number of register stages (≥1)
- RST_VAL, '0, WIDTH-bit value loaded into every data stage on reset
- clk  input  1  clock; all state updates on posedge clk
- rst_n  input  1  reset: synchronous, active-low; sampled on posedge clk
- d  input  WIDTH  input data
- d_valid  input  1  producer offers d this cycle
- d_ready  output  1  pipeline accepts d this cycle
- q  output  WIDTH  output data (last stage)
- q_valid  output  1  q holds a valid item
- q_ready  input  1  consumer takes q this cycle
- count  output  $clog2(DEPTH+1)  number of valid items held, 0..DEPTH
- flush  input  1  synchronous discard of all held items (present only with DFF_PIPE_FLUSH_EN)

## Operation
- State: per stage i (0 = input, DEPTH-1 = output): data[i], vld[i]; plus count.
- Reset (rst_n=0 at edge): vld[*]=0, data[*]=RST_VAL, count=0. Hence q=RST_VAL, q_valid=0. d_ready=1 once reset is released.
- Stage advance: adv[DEPTH-1] = !vld[DEPTH-1] || q_ready; adv[i] = !vld[i] || adv[i+1].
- d_ready = adv[0]. The ready chain is combinational, so q_ready→d_ready is a combinational path.
- On an edge with adv[i]: stage i loads from stage i-1. For stage 0 the source is d/d_valid, qualified by d_ready. When adv[i]=0, stage i holds.
- Push = d_valid && d_ready. Pop = q_valid && q_ready.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Invariant: count equals the popcount of vld.
- Items leave in the order they entered; none are dropped or duplicated.
- Bubbles: an empty stage ahead of a stalled item is filled on the next edge, so items compress toward the output while q_ready=0.
- Full (count=DEPTH): d_ready = q_ready. Push and pop in the same cycle keep count=DEPTH.
- Empty (count=0): d_ready=1 and q_valid=0. q holds its last value and must not be interpreted.
- Inputs are ignored when d_ready=0, with no side effects.

## Timing
- Latency: an item pushed at edge N into an empty, unstalled pipe appears with q_valid=1 after edge N+DEPTH-1. It is visible in the cycle following that edge, which is DEPTH edges of registering including the capture edge.
- Throughput: 1 item/cycle when d_valid=1 and q_ready=1 continuously.
- q and q_valid are registered outputs. d_ready and count follow: d_ready is combinational from vld and q_ready; count is registered.
- Stalled output: while q_valid=1 and q_ready=0, q and q_valid stay stable until a pop.
- Priority at an edge: rst_n=0 > flush=1 > normal advance.
- Reset mid-operation clears everything on that edge. In-flight items are lost.

## Configuration
- DFF_PIPE_FLUSH_EN defined: the flush port exists.
  - flush=1 at an edge clears vld[*] and sets count=0.
  - Data registers keep their values.
  - A push in the same cycle is discarded.
  - d_ready is not gated by flush.
- DFF_PIPE_FLUSH_EN undefined: there is no flush port or logic. Only rst_n clears the pipeline.

## Test plan
- Reset: WIDTH=8, DEPTH=3, RST_VAL=8'hA5. Hold rst_n=0 for 2 edges with d_valid=1 → q=8'hA5, q_valid=0, count=0, d_ready=1.
- Latency/throughput: q_ready=1; push 8'h01..8'h08 on consecutive edges → q_valid rises 3 edges after the first push; q=01..08 on consecutive cycles with no gaps; count settles at 3.
- Backpressure fill: q_ready=0; push 10,11,12 → count=3, d_ready=0, q=10 stable. A 4th offer 13 is not accepted. Raising q_ready for 1 cycle pops 10 and accepts 13 in the same edge, and count stays 3.
- Bubble compression: push 20, idle 2 cycles, push 21, with q_ready=0 throughout → q=20 and count=2. Then q_ready=1 yields 20 and 21 on back-to-back cycles.
- Mid-stream reset: with count=2, drive rst_n=0 for one edge → count=0, q_valid=0. The next push 30 emerges alone after 3 edges.
- Flush (DFF_PIPE_FLUSH_EN): with count=3, assert flush with d_valid=1, d=40 → next cycle count=0, q_valid=0, and 40 never appears at q.

Source files
------------

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage elastic register pipeline with valid/ready on both sides.
// Optional synchronous flush port enabled by defining DFF_PIPE_FLUSH_EN.
module dff_pipe #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
`ifdef DFF_PIPE_FLUSH_EN
    input  logic                           flush,
`endif
    input  logic [WIDTH-1:0]               d,
    input  logic                           d_valid,
    output logic                           d_ready,
    output logic [WIDTH-1:0]               q,
    output logic                           q_valid,
    input  logic                           q_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            r_vld;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [CW-1:0]               r_count;

    logic [DEPTH-1:0]            w_adv;
    logic [DEPTH:0]              w_src_vld;
    logic [DEPTH:0][WIDTH-1:0]   w_src_data;
    logic                        w_push;
    logic                        w_pop;

    // Stage i advances when the consumer takes q or any stage from i to the output is empty.
    for (genvar i = 0; i < DEPTH; i++) begin : g_adv
        assign w_adv[i] = q_ready | ~(&r_vld[DEPTH-1:i]);
    end

    // Source of stage i lives at index i: index 0 is the producer, index i+1 is stage i.
    assign w_src_vld  = {r_vld, d_valid};
    assign w_src_data = {r_data, d};

    assign d_ready = w_adv[0];
    assign w_push  = d_valid & w_adv[0];
    assign w_pop   = r_vld[DEPTH-1] & q_ready;

    assign q       = r_data[DEPTH-1];
    assign q_valid = r_vld[DEPTH-1];
    assign count   = r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_data  <= {DEPTH{RST_VAL}};
            r_count <= '0;
        end
`ifdef DFF_PIPE_FLUSH_EN
        else if (flush) begin
            r_vld   <= '0;
            r_count <= '0;
        end
`endif
        else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_adv[i]) begin
                    r_vld[i] <= w_src_vld[i];
                    // Bubbles don't overwrite data, so q keeps its last value when empty.
                    if (w_src_vld[i])
                        r_data[i] <= w_src_data[i];
                end
            end
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end
endmodule
